// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle control unit for the MIPS-subset CPU. Sequences
//                each instruction through IF/ID/EXE/MEM/WB, drives datapath
//                enables and mux selects, and owns PC write enable / next-PC
//                select so the PC advances exactly once per instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic [2:0] state,
  output logic       halted
);

  localparam logic [2:0] c_S_IF   = 3'b000;
  localparam logic [2:0] c_S_ID   = 3'b001;
  localparam logic [2:0] c_S_EXE  = 3'b010;
  localparam logic [2:0] c_S_MEM  = 3'b011;
  localparam logic [2:0] c_S_WB   = 3'b100;
  localparam logic [2:0] c_S_HALT = 3'b111;

  localparam logic [5:0] c_OP_ADD  = 6'b000000;
  localparam logic [5:0] c_OP_SUB  = 6'b000001;
  localparam logic [5:0] c_OP_ADDI = 6'b000010;
  localparam logic [5:0] c_OP_OR   = 6'b010000;
  localparam logic [5:0] c_OP_AND  = 6'b010001;
  localparam logic [5:0] c_OP_ORI  = 6'b010010;
  localparam logic [5:0] c_OP_SLL  = 6'b011000;
  localparam logic [5:0] c_OP_SLT  = 6'b100110;
  localparam logic [5:0] c_OP_SW   = 6'b110000;
  localparam logic [5:0] c_OP_LW   = 6'b110001;
  localparam logic [5:0] c_OP_BEQ  = 6'b110100;
  localparam logic [5:0] c_OP_J    = 6'b111000;
  localparam logic [5:0] c_OP_JR   = 6'b111001;
  localparam logic [5:0] c_OP_JAL  = 6'b111010;

  logic [2:0] r_state;
  logic [2:0] w_next;

  // ALU-side decode of the current opcode; w_alu_op_ok marks opcodes that go through EXE
  logic       w_alu_op_ok;
  logic [2:0] w_aluop;
  logic       w_srca;
  logic       w_srcb;
  logic       w_ext;

  // Decode ALU controls straight from the opcode (not latched; IR holds it stable)
  always_comb begin
    w_alu_op_ok = 1'b1;
    w_aluop     = 3'b000;
    w_srca      = 1'b0;
    w_srcb      = 1'b0;
    w_ext       = 1'b0;
    case (opcode)
      c_OP_ADD:  w_aluop = 3'b000;
      c_OP_SUB:  w_aluop = 3'b001;
      c_OP_ADDI: begin w_aluop = 3'b000; w_srcb = 1'b1; w_ext = 1'b1; end
      c_OP_OR:   w_aluop = 3'b011;
      c_OP_AND:  w_aluop = 3'b100;
      c_OP_ORI:  begin w_aluop = 3'b011; w_srcb = 1'b1; end
      c_OP_SLL:  begin w_aluop = 3'b010; w_srca = 1'b1; end
      c_OP_SLT:  w_aluop = 3'b101;
      c_OP_SW,
      c_OP_LW:   begin w_aluop = 3'b000; w_srcb = 1'b1; w_ext = 1'b1; end
      c_OP_BEQ:  begin w_aluop = 3'b001; w_ext = 1'b1; end
      default:   w_alu_op_ok = 1'b0;
    endcase
  end

  // State register: synchronous reset returns to IF from any state
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_S_IF;
    else       r_state <= w_next;
  end

  // Next-state sequencing
  always_comb begin
    w_next = c_S_IF;
    case (r_state)
      c_S_IF:  w_next = c_S_ID;
      c_S_ID: begin
        if (opcode == HALT_OP)  w_next = c_S_HALT;
        else if (w_alu_op_ok)   w_next = c_S_EXE;
        else                    w_next = c_S_IF;   // jumps and undefined (nop)
      end
      c_S_EXE: begin
        if (opcode == c_OP_SW || opcode == c_OP_LW) w_next = c_S_MEM;
        else if (opcode == c_OP_BEQ)                w_next = c_S_IF;
        else                                        w_next = c_S_WB;
      end
      c_S_MEM:  w_next = (opcode == c_OP_LW) ? c_S_WB : c_S_IF;
      c_S_WB:   w_next = c_S_IF;
      c_S_HALT: w_next = c_S_HALT;
      default:  w_next = c_S_IF;
    endcase
  end

  // Output decode; reset forces PCWre so the PC clears on the same edge
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = 3'b000;
    mRD       = 1'b0;
    mWR       = 1'b0;
    halted    = 1'b0;
    if (reset) begin
      PCWre = 1'b1;
    end else begin
      case (r_state)
        c_S_IF: IRWre = 1'b1;
        c_S_ID: begin
          case (opcode)
            c_OP_J:  begin PCWre = 1'b1; PCSrc = 2'b11; end
            c_OP_JR: begin PCWre = 1'b1; PCSrc = 2'b10; end
            c_OP_JAL: begin
              PCWre  = 1'b1;
              PCSrc  = 2'b11;
              RegWre = 1'b1;     // $31 <- PC+4
            end
            default: begin
              if (opcode != HALT_OP && !w_alu_op_ok) PCWre = 1'b1;  // nop
            end
          endcase
        end
        c_S_EXE: begin
          ALUOp   = w_aluop;
          ALUSrcA = w_srca;
          ALUSrcB = w_srcb;
          ExtSel  = w_ext;
          if (opcode == c_OP_BEQ) begin
            PCWre = 1'b1;
            PCSrc = zero ? 2'b01 : 2'b00;
          end
        end
        c_S_MEM: begin
          if (opcode == c_OP_SW) begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end else if (opcode == c_OP_LW) begin
            mRD = 1'b1;
          end
        end
        c_S_WB: begin
          ALUOp     = w_aluop;
          ALUSrcA   = w_srca;
          ALUSrcB   = w_srcb;
          ExtSel    = w_ext;
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          PCWre     = 1'b1;
          RegDst    = (opcode == c_OP_ADDI || opcode == c_OP_ORI ||
                       opcode == c_OP_LW) ? 2'b01 : 2'b10;
          DBDataSrc = (opcode == c_OP_LW);
        end
        c_S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control unit for the MIPS-subset CPU. It sequences each instruction through IF/ID/EXE/MEM/WB and drives every datapath enable and mux select. It owns the program-counter write enable (PCWre) and next-PC select, so the PC register advances exactly once per instruction. It sits between the instruction register (opcode source) and the datapath (ALU zero flag back in).

Parameters:
HALT_OP, 6'b111111, opcode that freezes the machine until reset

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high; forces state IF on next edge
opcode  input  6  IR[31:26]; stable from end of IF until next IF
zero  input  1  ALU zero flag, valid during EXE
PCWre  output  1  PC write enable (PC also clears only when PCWre=1)
PCSrc  output  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs (jr), 11 jump target
IRWre  output  1  instruction register load
RegWre  output  1  register file write
RegDst  output  2  00 $31, 01 rt, 10 rd
WrRegDSrc  output  1  0 PC+4 (jal), 1 DB result
DBDataSrc  output  1  0 ALU result, 1 data memory
ALUSrcA  output  1  0 rs, 1 shamt
ALUSrcB  output  1  0 rt, 1 extended immediate
ExtSel  output  1  0 zero-extend, 1 sign-extend
ALUOp  output  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt
mRD  output  1  data memory read
mWR  output  1  data memory write
state  output  3  current state, for debug
halted  output  1  1 in HALT

Behaviour:
- Clock is clk, reset is reset. Reset is synchronous and active-high, on the single clock.
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111. One state register. Outputs are combinational from state, opcode and zero.
- Default for every output is 0. Only the assertions listed below are non-zero.
- While reset=1, outputs are PCWre=1 and PCSrc=00, with all other enables 0. This lets the PC clear on the same edge. On that edge the state becomes IF.
- After reset is released, the first cycle is IF.
- IF: IRWre=1. Next state is ID.
- ID, by opcode:
  - j (111000): PCWre=1, PCSrc=11. Next state is IF.
  - jr (111001): PCWre=1, PCSrc=10. Next state is IF.
  - jal (111010): PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0. Next state is IF.
  - HALT_OP: next state is HALT.
  - Undefined opcode: acts as nop. PCWre=1, PCSrc=00. Next state is IF.
  - All other supported opcodes: next state is EXE.
- EXE ALU settings:
  - add 000000: ALUOp=000.
  - sub 000001: ALUOp=001.
  - addi 000010: ALUOp=000, ALUSrcB=1, ExtSel=1.
  - or 010000: ALUOp=011.
  - and 010001: ALUOp=100.
  - ori 010010: ALUOp=011, ALUSrcB=1, ExtSel=0.
  - sll 011000: ALUOp=010, ALUSrcA=1.
  - slt 100110: ALUOp=101.
  - sw 110000 and lw 110001: ALUOp=000, ALUSrcB=1, ExtSel=1.
  - beq 110100: ALUOp=001, ExtSel=1.
- EXE next state:
  - beq: PCWre=1 and PCSrc = zero ? 01 : 00. Next state is IF.
  - sw and lw: next state is MEM.
  - All others: next state is WB.
- MEM:
  - sw: mWR=1, PCWre=1, PCSrc=00. Next state is IF.
  - lw: mRD=1. Next state is WB.
- WB: RegWre=1, WrRegDSrc=1, PCWre=1, PCSrc=00. Next state is IF.
  - RegDst=01 for addi, ori and lw; 10 otherwise.
  - DBDataSrc=1 for lw; 0 otherwise.
  - ALU controls are held at their EXE values.
- HALT: all enables 0, halted=1. The state stays in HALT until reset.
- Invariants:
  - PCWre is high in exactly one cycle per instruction, and never in IF.
  - RegWre and mWR are never high together.
- Cycle counts: j/jr/jal/nop = 2, beq = 3, R-type/imm = 4, sw = 4, lw = 5.
- Reset mid-instruction (any state, including HALT): the next state is IF. No write enable other than PCWre is asserted in the reset cycle.
- An opcode change outside IF is not legal. The controller decodes whatever is present and does not latch it.

Test Plan:
- Hold reset=1 for 2 cycles: PCWre=1, PCSrc=00, IRWre=RegWre=mWR=0. After release, state=000 and IRWre=1.
- add (000000): states 000→001→010→100→000. PCWre=1 only in WB, RegWre=1 and RegDst=10 in WB, ALUOp=000.
- beq, twice:
  - With zero=1: PCSrc=01 and PCWre=1 in EXE, then back to IF, 3 cycles total.
  - Repeat with zero=0: PCSrc=00.
- lw (110001): 5 states IF-ID-EXE-MEM-WB. mRD=1 in MEM, DBDataSrc=1, RegDst=01, RegWre=1 in WB.
- sw (110000): mWR=1 and PCWre=1 in MEM only. RegWre stays 0 throughout.
- jal (111010): in ID, PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
- Halt and reset:
  - Opcode 111111: state 111 and halted=1, held for 10 cycles with PCWre=0.
  - Reset mid-lw (in MEM): next state is IF and mRD is 0 during the reset cycle.
